axi_lite_regfile: RTL and testbench
===================================

Name: axi_lite_regfile

Overview:
Parametrised AXI4-Lite slave register file and the next generation of the team's fixed four-register slave. It adds configurable width, register count and base address, byte strobes, independent AW/W acceptance, and per-register read-only hardware status. Read-write registers drive fabric logic through reg_out; read-only registers reflect hw_status_in. It sits on the peripheral interconnect as the control/status front end of an IP block.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, register and bus width; must be 32 or 64
NUM_REGS, 8, number of registers (2..256)
BASE_ADDR, 0, byte address of register 0; aligned to NUM_REGS*DATA_WIDTH/8
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only (sourced from hw_status_in)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  write byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read valid
rready  in  1  read ready
hw_status_in  in  NUM_REGS*DATA_WIDTH  packed status inputs; slice i used when RO_MASK[i]=1
reg_out  out  NUM_REGS*DATA_WIDTH  packed register contents (RW slices; RO slices read 0)
wr_pulse  out  NUM_REGS  one-cycle strobe on each successful write to register i

Behaviour:
- Reset (aresetn low, asynchronous): all RW registers 0; bvalid, rvalid, wr_pulse 0; bresp, rresp 00; rdata 0; AW/W holding slots empty. awready, wready, arready are 0 while aresetn is low.
- Decode: off = addr - BASE_ADDR; BPW = DATA_WIDTH/8. off not a multiple of BPW -> SLVERR (10). Index off/BPW >= NUM_REGS, or addr < BASE_ADDR -> DECERR (11). Otherwise OKAY (00), with the RO write rule below.
- Write path: separate one-entry slots for AW and W. awready = aresetn & ~aw_held & ~bvalid; wready = aresetn & ~w_held & ~bvalid. AW and W may arrive in either order or in the same cycle; each is captured on its own handshake.
- Commit: on the clock edge after both slots are full, the decoded register is updated byte-wise (byte k written iff wstrb[k]). bvalid <= 1, bresp <= decode result, both slots cleared, wr_pulse[i] high for exactly that one cycle. Latency from the later handshake edge to bvalid high is 1 cycle.
- A write to an RO register returns SLVERR and changes nothing. An error write changes no register and raises no wr_pulse. wstrb=0 to a valid RW register gives OKAY, no data change, and wr_pulse still fires.
- B channel: bvalid and bresp are held stable until bready. The slot clears on the bvalid&bready edge. No new AW/W is accepted while bvalid=1.
- Read path: arready = aresetn & ~rvalid. On the AR handshake edge, rdata, rresp and rvalid<=1 are registered, so latency is 1 cycle.
  - RO index: rdata = hw_status_in slice sampled at that edge.
  - RW index: rdata = current stored value.
  - Error: rdata = 0.
- rdata and rresp are held stable until rready. rvalid clears on the rvalid&rready edge, and arready returns the next cycle. Maximum read throughput is 1 per 2 cycles.
- Simultaneous read and write commit on the same register at the same edge: the read returns the pre-write value.
- Read and write channels are fully independent and may overlap.
- Reset mid-transaction: all pending AW/W/B/R state is discarded and no partial register update occurs.

Test Plan:
- AW then W 3 cycles later, addr BASE+0x4, wdata 0xDEADBEEF, wstrb 0xF -> bvalid 1 cycle after the W handshake, bresp 00, wr_pulse[1] for 1 cycle, reg_out slice1 = 0xDEADBEEF.
- W before AW, and AW+W same cycle, wstrb 0x5 over 0xFFFFFFFF with wdata 0 -> register 0xFF00FF00 in both cases, bresp 00.
- Read reg1 with rready held low 4 cycles -> rvalid 1 cycle after AR, rdata 0xDEADBEEF stable, arready 0 until the cycle after rready.
- RO_MASK=0x4: write reg2 -> bresp 10, no wr_pulse. Read reg2 with hw_status_in slice2=0x1234 -> rdata 0x1234, rresp 00.
- Address BASE+0x2 -> SLVERR. BASE+NUM_REGS*4 -> DECERR. Read of either -> rdata 0.
- aresetn pulsed low while bvalid=1 awaiting bready -> bvalid 0 and registers 0 immediately. A new write after release completes normally.

Source files
------------

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: parametrised AXI4-Lite slave register file.
// Read-write registers drive fabric logic through reg_out; read-only registers
// (RO_MASK bit set) return the matching hw_status_in slice on reads.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   aw*/w*/b*              AXI4-Lite write address, data and response channels
//   ar*/r*                 AXI4-Lite read address and data channels
//   hw_status_in           packed status inputs, slice i read when RO_MASK[i]=1
//   reg_out                packed register contents (RO slices read 0)
//   wr_pulse               one-cycle strobe per successful register write
module axi_lite_regfile #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK   = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned BPW    = DATA_WIDTH / 8;
  localparam int unsigned BSHIFT = $clog2(BPW);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Address classification: below base or past the last register is a decode
  // error, a misaligned offset inside the window is a slave error.
  function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    if (addr < BASE_ADDR) return RESP_DECERR;
    if (off[BSHIFT-1:0] != '0) return RESP_SLVERR;
    if ((off >> BSHIFT) >= ADDR_WIDTH'(NUM_REGS)) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] decode_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> BSHIFT);
  endfunction

  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [BPW-1:0]        w_strb_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [IDX_W-1:0]      wr_idx_c;
  logic [1:0]            wr_resp_c;
  logic                  commit_c;
  logic                  wr_en_c;
  logic [IDX_W-1:0]      rd_idx_c;
  logic [1:0]            rd_resp_c;
  logic [DATA_WIDTH-1:0] rd_data_c;

  // Ready signals: each slot accepts only while empty and no response pending.
  assign awready = aresetn & ~aw_held & ~bvalid;
  assign wready  = aresetn & ~w_held  & ~bvalid;
  assign arready = aresetn & ~rvalid;

  // Write decode from the held address; RO targets turn into slave errors.
  always_comb begin
    wr_idx_c  = decode_idx(aw_addr_q);
    wr_resp_c = decode_resp(aw_addr_q);
    if (wr_resp_c == RESP_OKAY && RO_MASK[wr_idx_c]) wr_resp_c = RESP_SLVERR;
    commit_c  = aw_held & w_held;
    wr_en_c   = commit_c & (wr_resp_c == RESP_OKAY);
  end

  // Read decode and data select from the live AR address.
  always_comb begin
    rd_idx_c  = decode_idx(araddr);
    rd_resp_c = decode_resp(araddr);
    rd_data_c = '0;
    if (rd_resp_c == RESP_OKAY) begin
      if (RO_MASK[rd_idx_c]) rd_data_c = hw_status_in[32'(rd_idx_c) * DATA_WIDTH +: DATA_WIDTH];
      else                   rd_data_c = regs[rd_idx_c];
    end
  end

  // Write slots, commit and B channel.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      wr_pulse  <= '0;
    end else begin
      wr_pulse <= '0;
      if (awvalid && awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (wvalid && wready) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit_c) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_resp_c;
        if (wr_en_c) wr_pulse <= NUM_REGS'(1) << wr_idx_c;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Register storage with byte-strobe updates.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en_c) begin
      for (int unsigned k = 0; k < BPW; k++) begin
        if (w_strb_q[k]) regs[wr_idx_c][k*8 +: 8] <= w_data_q[k*8 +: 8];
      end
    end
  end

  // R channel: data captured at the AR handshake, held until rready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rresp  <= rd_resp_c;
      rdata  <= rd_data_c;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  // RO slices are driven to zero on reg_out.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs[g];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile: table-driven and randomized bench for axi_lite_regfile
// (8 x 32-bit registers at 0x1000, register 2 read-only).
module tb_axi_lite_regfile;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [7:0]  RO   = 8'h04;

  logic           aclk;
  logic           aresetn;
  logic [AW-1:0]  awaddr;
  logic           awvalid;
  logic           awready;
  logic [DW-1:0]  wdata;
  logic [3:0]     wstrb;
  logic           wvalid;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;
  logic [AW-1:0]  araddr;
  logic           arvalid;
  logic           arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready;
  logic [NR*DW-1:0] hw;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]  wr_pulse;

  axi_lite_regfile #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR(BASE), .RO_MASK(RO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .hw_status_in(hw), .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  int tests;
  int fails;
  logic [31:0] model [NR];

  always #5 aclk = ~aclk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: handshake not seen within 20 cycles at %0t", nm, $time);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference: response from address arithmetic alone.
  function automatic logic [1:0] model_resp(input logic [31:0] a, input bit is_wr);
    int unsigned off;
    if (a < BASE) return 2'b11;
    off = a - BASE;
    if (off % 4 != 0) return 2'b10;
    if (off / 4 >= NR) return 2'b11;
    if (is_wr && RO[off / 4]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned idx;
    if (model_resp(a, 1'b0) != 2'b00) return 32'h0;
    idx = (a - BASE) / 4;
    if (RO[idx]) return hw[idx*32 +: 32];
    return model[idx];
  endfunction

  task automatic check_regs(input string nm);
    for (int i = 0; i < NR; i++)
      check(nm, reg_out[i*32 +: 32], RO[i] ? 32'h0 : model[i]);
  endtask

  task automatic send_aw(input logic [31:0] a);
    int n;
    n = 0;
    awaddr = a;
    awvalid = 1'b1;
    while (!awready && n < 20) begin tick(); n++; end
    if (!awready) timeout("aw_handshake");
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    while (!wready && n < 20) begin tick(); n++; end
    if (!wready) timeout("w_handshake");
    tick();
    wvalid = 1'b0;
  endtask

  // mode 0: AW and W together; 1: AW then W after gap; 2: W then AW after gap.
  task automatic do_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int mode, input int gap,
                          input logic [1:0] eresp);
    int n;
    int unsigned idx;
    logic [7:0] epulse;
    n = 0;
    if (mode == 0) begin
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      while (!(awready && wready) && n < 20) begin tick(); n++; end
      if (!(awready && wready)) timeout({nm, "_awready"});
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      if (mode == 1) send_aw(a); else send_w(d, s);
      repeat (gap) begin
        check({nm, "_bvalid_gap"}, 32'(bvalid), 32'd0);
        tick();
      end
      if (mode == 1) send_w(d, s); else send_aw(a);
    end
    check({nm, "_bvalid_early"}, 32'(bvalid), 32'd0);
    tick();
    check({nm, "_bvalid"}, 32'(bvalid), 32'd1);
    check({nm, "_bresp"}, 32'(bresp), 32'(eresp));
    epulse = 8'h00;
    if (eresp == 2'b00) begin
      idx = (a - BASE) / 4;
      epulse[idx] = 1'b1;
      for (int k = 0; k < 4; k++)
        if (s[k]) model[idx][k*8 +: 8] = d[k*8 +: 8];
    end
    check({nm, "_wr_pulse"}, 32'(wr_pulse), 32'(epulse));
    check_regs({nm, "_reg_out"});
    repeat ($urandom_range(0, 2)) begin
      tick();
      check({nm, "_pulse_once"}, 32'(wr_pulse), 32'd0);
      check({nm, "_bvalid_hold"}, 32'(bvalid), 32'd1);
      check({nm, "_bresp_hold"}, 32'(bresp), 32'(eresp));
      check({nm, "_awready_busy"}, 32'(awready), 32'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({nm, "_bvalid_clr"}, 32'(bvalid), 32'd0);
    check({nm, "_awready_back"}, 32'(awready), 32'd1);
  endtask

  task automatic do_read(input string nm, input logic [31:0] a, input int hold,
                         input logic [1:0] eresp, input logic [31:0] edata);
    int n;
    n = 0;
    araddr = a;
    arvalid = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    if (!arready) timeout({nm, "_arready"});
    tick();
    arvalid = 1'b0;
    check({nm, "_rvalid"}, 32'(rvalid), 32'd1);
    check({nm, "_rresp"}, 32'(rresp), 32'(eresp));
    check({nm, "_rdata"}, rdata, edata);
    check({nm, "_arready_busy"}, 32'(arready), 32'd0);
    repeat (hold) begin
      tick();
      check({nm, "_rvalid_hold"}, 32'(rvalid), 32'd1);
      check({nm, "_rdata_hold"}, rdata, edata);
      check({nm, "_arready_hold"}, 32'(arready), 32'd0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check({nm, "_rvalid_clr"}, 32'(rvalid), 32'd0);
    check({nm, "_arready_back"}, 32'(arready), 32'd1);
  endtask

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          mode;   // write mode, or rready hold cycles for reads
    int          gap;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [$];
  logic [31:0] ra;
  int sel;

  initial begin
    tests = 0; fails = 0;
    aclk = 1'b0; aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      hw[i*32 +: 32] = $urandom;
      model[i] = 32'h0;
    end
    hw[2*32 +: 32] = 32'h0000_1234;

    tbl.push_back('{0, 32'h1004, 32'hDEADBEEF, 4'hF, 1, 3, 2'b00, 32'h0});
    tbl.push_back('{0, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b00, 32'h0});
    tbl.push_back('{0, 32'h1000, 32'h00000000, 4'h5, 2, 2, 2'b00, 32'h0});
    tbl.push_back('{0, 32'h1014, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b00, 32'h0});
    tbl.push_back('{0, 32'h1014, 32'h00000000, 4'h5, 0, 0, 2'b00, 32'h0});
    tbl.push_back('{0, 32'h1008, 32'hCAFEF00D, 4'hF, 0, 0, 2'b10, 32'h0});
    tbl.push_back('{0, 32'h1002, 32'h11111111, 4'hF, 0, 0, 2'b10, 32'h0});
    tbl.push_back('{0, 32'h1020, 32'h22222222, 4'hF, 1, 1, 2'b11, 32'h0});
    tbl.push_back('{0, 32'h0FFC, 32'h33333333, 4'hF, 2, 1, 2'b11, 32'h0});
    tbl.push_back('{0, 32'h101C, 32'h12345678, 4'h0, 1, 1, 2'b00, 32'h0});
    tbl.push_back('{1, 32'h1004, 32'h0, 4'h0, 4, 0, 2'b00, 32'hDEADBEEF});
    tbl.push_back('{1, 32'h1008, 32'h0, 4'h0, 0, 0, 2'b00, 32'h00001234});
    tbl.push_back('{1, 32'h1002, 32'h0, 4'h0, 1, 0, 2'b10, 32'h0});
    tbl.push_back('{1, 32'h1020, 32'h0, 4'h0, 0, 0, 2'b11, 32'h0});
    tbl.push_back('{1, 32'h0FFC, 32'h0, 4'h0, 0, 0, 2'b11, 32'h0});
    tbl.push_back('{1, 32'h1000, 32'h0, 4'h0, 0, 0, 2'b00, 32'hFF00FF00});
    tbl.push_back('{1, 32'h1014, 32'h0, 4'h0, 2, 0, 2'b00, 32'hFF00FF00});
    tbl.push_back('{1, 32'h101C, 32'h0, 4'h0, 0, 0, 2'b00, 32'h0});

    // Reset state while aresetn is low.
    #12;
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    check_regs("rst_reg_out");
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tick();
    check("post_rst_awready", 32'(awready), 32'd1);
    check("post_rst_arready", 32'(arready), 32'd1);

    foreach (tbl[i]) begin
      if (tbl[i].is_rd)
        do_read($sformatf("tbl%0d_rd", i), tbl[i].addr, tbl[i].mode, tbl[i].resp, tbl[i].rdata);
      else
        do_write($sformatf("tbl%0d_wr", i), tbl[i].addr, tbl[i].data, tbl[i].strb,
                 tbl[i].mode, tbl[i].gap, tbl[i].resp);
    end

    // Read and write commit hitting register 3 on the same edge.
    do_write("pre_same", 32'h100C, 32'h11111111, 4'hF, 0, 0, 2'b00);
    awaddr = 32'h100C; wdata = 32'h22222222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h100C; arvalid = 1'b1;
    check("same_arready", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    model[3] = 32'h22222222;
    check("same_bvalid", 32'(bvalid), 32'd1);
    check("same_rvalid", 32'(rvalid), 32'd1);
    check("same_rdata_old", rdata, 32'h11111111);
    check("same_reg_out", reg_out[3*32 +: 32], 32'h22222222);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check("same_bvalid_clr", 32'(bvalid), 32'd0);
    check("same_rvalid_clr", 32'(rvalid), 32'd0);

    // Reset while a write response awaits bready.
    awaddr = 32'h1010; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("mid_bvalid_pending", 32'(bvalid), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    check("mid_bvalid_rst", 32'(bvalid), 32'd0);
    check("mid_awready_rst", 32'(awready), 32'd0);
    check("mid_bresp_rst", 32'(bresp), 32'd0);
    check_regs("mid_reg_out_rst");
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tick();
    do_write("after_rst", 32'h1010, 32'hA5A5A5A5, 4'hF, 1, 1, 2'b00);
    do_read("after_rst_rd", 32'h1010, 1, 2'b00, 32'hA5A5A5A5);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 11);
      if (sel < 10)       ra = BASE + 32'(sel * 4);
      else if (sel == 10) ra = BASE + 32'($urandom_range(0, 31));
      else                ra = BASE - 32'(4 * $urandom_range(1, 4));
      for (int i = 0; i < NR; i++) hw[i*32 +: 32] = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write("rnd_wr", ra, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), model_resp(ra, 1'b1));
      else
        do_read("rnd_rd", ra, int'($urandom_range(0, 2)), model_resp(ra, 1'b0), model_read(ra));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
